// File: rtl/ch_pkg.sv
// Shared types and helpers for the channel buffer: tagged FIFO word,
// byte-lane swap and sticky error bit positions.
package ch_pkg;

  localparam int CH_DW     = 64;
  localparam int CH_DW_MAX = 512;

  localparam int ERR_OVF = 0;
  localparam int ERR_UDF = 1;

  typedef struct packed {
    logic             last;
    logic [CH_DW-1:0] data;
  } ch_word_t;

  // Reverses the low nbytes bytes of x when en is set; callers zero-extend
  // their DW-wide data into the CH_DW_MAX container and truncate the result.
  function automatic logic [CH_DW_MAX-1:0] ch_swap(input logic [CH_DW_MAX-1:0] x,
                                                   input int                   nbytes,
                                                   input bit                   en);
    logic [CH_DW_MAX-1:0] r;
    r = x;
    if (en) begin
      r = '0;
      for (int k = 0; k < CH_DW_MAX / 8; k++) begin
        if (k < nbytes) r[(nbytes - 1 - k) * 8 +: 8] = x[k * 8 +: 8];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ch_sfifo.sv
// Synchronous first-word fall-through FIFO with registered level and
// single-cycle overflow/underflow pulses for rejected operations.
module ch_sfifo
  import ch_pkg::*;
#(
  parameter int W  = 65,
  parameter int AW = 9
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         clr_i,
  input  logic         wr_i,
  input  logic         rd_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic [AW:0]  level_o,
  output logic         full_o,
  output logic         empty_o,
  output logic         ovf_o,
  output logic         udf_o
);

  localparam int DEPTH = 2 ** AW;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   level_q, level_d;
  logic          wr_ok, rd_ok;

  assign full_o  = (level_q == (AW + 1)'(DEPTH));
  assign empty_o = (level_q == '0);

  // A full FIFO still takes a write when a read frees the slot in the same cycle.
  assign wr_ok = wr_i & (~full_o | rd_i);
  assign rd_ok = rd_i & ~empty_o;
  assign ovf_o = wr_i & ~wr_ok;
  assign udf_o = rd_i & empty_o;

  assign level_o = level_q;
  assign dout_o  = mem_q[rptr_q];

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (clr_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (wr_ok) wptr_d = wptr_q + 1'b1;
      if (rd_ok) rptr_d = rptr_q + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_ok && !clr_i) mem_q[wptr_q] <= din_i;
  end

endmodule

// File: rtl/ch_buf.sv
// Channel buffer between the DMA engine and the compression unit: two tagged
// FIFOs with byte swap, threshold flags, word counters and sticky errors.
module ch_buf
  import ch_pkg::*;
#(
  parameter int DW           = 64,
  parameter int AW           = 9,
  parameter int SRC_PFULL    = 256,
  parameter int DST_PFULL    = 256,
  parameter int AEMPTY       = 1,
  parameter int AFULL_MARGIN = 2,
  parameter int SWAP_EN      = 1
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_n,
  input  logic          m_reset,

  input  logic          src_xfer,
  input  logic          src_last,
  input  logic [DW-1:0] src_dat_o,
  output logic          src_stop,
  output logic          src_start,
  output logic          src_end,

  input  logic          m_src_getn,
  output logic [DW-1:0] m_src,
  output logic          m_src_last,
  output logic          m_src_empty,
  output logic          m_src_almost_empty,

  input  logic          m_dst_putn,
  input  logic [DW-1:0] m_dst,
  input  logic          m_dst_last,
  output logic          m_dst_full,
  output logic          m_dst_almost_full,
  input  logic          m_endn,

  input  logic          dst_xfer,
  input  logic          dst_last_pop,
  output logic [DW-1:0] dst_dat_i,
  output logic          dst_stop,
  output logic          dst_start,
  output logic          dst_end,

  output logic [AW:0]   src_level,
  output logic [AW:0]   dst_level,
  output logic [15:0]   ocnt,
  output logic [15:0]   icnt,
  output logic [1:0]    err
);

  localparam int DEPTH = 2 ** AW;
  localparam int LW    = AW + 1;

  logic [DW-1:0] src_sw, dst_sw;
  logic [DW:0]   src_head, dst_head;
  logic          src_empty, src_full, src_ovf, src_udf;
  logic          dst_empty, dst_full, dst_ovf, dst_udf;
  logic          dst_rd;
  logic [LW-1:0] src_free;

  logic [15:0]   icnt_q, icnt_d;
  logic [15:0]   ocnt_q, ocnt_d;
  logic [1:0]    err_q, err_d;

  assign src_sw = DW'(ch_swap(CH_DW_MAX'(src_dat_o), DW / 8, SWAP_EN != 0));
  assign dst_sw = DW'(ch_swap(CH_DW_MAX'(m_dst), DW / 8, SWAP_EN != 0));

  ch_sfifo #(.W(DW + 1), .AW(AW)) u_src_fifo (
    .clk_i   (wb_clk_i),
    .rst_n_i (wb_rst_n),
    .clr_i   (m_reset),
    .wr_i    (src_xfer),
    .rd_i    (~m_src_getn),
    .din_i   ({src_last, src_sw}),
    .dout_o  (src_head),
    .level_o (src_level),
    .full_o  (src_full),
    .empty_o (src_empty),
    .ovf_o   (src_ovf),
    .udf_o   (src_udf)
  );

  // A last-tagged head is held back from dst_xfer and only leaves on dst_last_pop.
  assign dst_end = ~dst_empty & dst_head[DW];
  assign dst_rd  = (dst_xfer & ~dst_end) | (dst_last_pop & dst_end);

  ch_sfifo #(.W(DW + 1), .AW(AW)) u_dst_fifo (
    .clk_i   (wb_clk_i),
    .rst_n_i (wb_rst_n),
    .clr_i   (m_reset),
    .wr_i    (~m_dst_putn),
    .rd_i    (dst_rd),
    .din_i   ({m_dst_last, dst_sw}),
    .dout_o  (dst_head),
    .level_o (dst_level),
    .full_o  (dst_full),
    .empty_o (dst_empty),
    .ovf_o   (dst_ovf),
    .udf_o   (dst_udf)
  );

  assign m_src              = src_head[DW-1:0];
  assign m_src_last         = src_head[DW];
  assign m_src_empty        = src_empty;
  assign m_src_almost_empty = (src_level <= LW'(AEMPTY));

  assign src_free  = LW'(DEPTH) - src_level;
  assign src_stop  = (src_level >= LW'(SRC_PFULL));
  assign src_start = ~m_reset & (src_free > LW'(AFULL_MARGIN));
  assign src_end   = 1'b0;

  assign m_dst_full        = dst_full;
  assign m_dst_almost_full = (dst_level >= LW'(DST_PFULL));
  assign dst_stop          = m_dst_almost_full;
  assign dst_start         = m_dst_almost_full | (~m_endn & ~dst_empty);
  assign dst_dat_i         = dst_head[DW-1:0];

  always_comb begin
    icnt_d = icnt_q;
    ocnt_d = ocnt_q;
    err_d  = err_q;
    if (m_reset) begin
      icnt_d = '0;
      ocnt_d = '0;
      err_d  = '0;
    end else begin
      if (src_xfer && !src_ovf) icnt_d = icnt_q + 16'd1;
      // ocnt tracks unit output attempts, so dropped pushes still count.
      if (!m_dst_putn && !m_dst_last) ocnt_d = ocnt_q + 16'd1;
      err_d[ERR_OVF] = err_q[ERR_OVF] | src_ovf | dst_ovf;
      err_d[ERR_UDF] = err_q[ERR_UDF] | src_udf | dst_udf;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      icnt_q <= '0;
      ocnt_q <= '0;
      err_q  <= '0;
    end else begin
      icnt_q <= icnt_d;
      ocnt_q <= ocnt_d;
      err_q  <= err_d;
    end
  end

  assign icnt = icnt_q;
  assign ocnt = ocnt_q;
  assign err  = err_q;

endmodule

// File: doc/ch_buf.md
Name: ch_buf

Overview:
- Parametrised successor of the channel buffer. It sits between the DMA engine (src/dst transfer side) and a compression unit (m_ side).
- Contains two synchronous tagged FIFOs:
  - src FIFO: DMA → unit.
  - dst FIFO: unit → DMA.
- Each FIFO word carries a last tag. Byte-lane swap is configurable.
- New relative to the previous generation: programmable thresholds, occupancy outputs, an input word counter, sticky overflow/underflow flags, and an explicit pop of the terminating word.

Parameters:
- DW, 64, data width on both sides; must be a multiple of 8.
- AW, 9, log2 of FIFO depth (depth = 2**AW).
- SRC_PFULL, 256, src occupancy at or above which src_stop asserts.
- DST_PFULL, 256, dst occupancy at or above which m_dst_almost_full and dst_stop assert.
- AEMPTY, 1, occupancy at or below which the almost_empty flags assert.
- AFULL_MARGIN, 2, src_start deasserts when free entries ≤ AFULL_MARGIN.
- SWAP_EN, 1, 1 = reverse byte order within DW on both data paths; 0 = pass straight through.

Ports:
- wb_clk_i in 1: clock.
- wb_rst_n in 1: reset, asynchronous, active-low.
- m_reset in 1: synchronous clear of both FIFOs, counters and flags.
- src_xfer in 1: write src_dat_o into the src FIFO.
- src_last in 1: last tag for the src write.
- src_dat_o in DW: src write data.
- src_stop out 1: src occupancy ≥ SRC_PFULL.
- src_start out 1: src has room; DMA may start a burst.
- src_end out 1: constant 0.
- m_src_getn in 1: active-low pop of the src FIFO.
- m_src out DW: src head word (first-word fall-through).
- m_src_last out 1: src head tag.
- m_src_empty out 1: src FIFO empty.
- m_src_almost_empty out 1: src FIFO almost empty.
- m_dst_putn in 1: active-low push into the dst FIFO.
- m_dst in DW: dst push data.
- m_dst_last in 1: dst push tag.
- m_dst_full out 1: dst FIFO full.
- m_dst_almost_full out 1: dst occupancy ≥ DST_PFULL.
- m_endn in 1: active-low "unit finished".
- dst_xfer in 1: DMA pops a dst word.
- dst_last_pop in 1: DMA consumes the terminating word.
- dst_dat_i out DW: dst head word.
- dst_stop out 1: equals m_dst_almost_full.
- dst_start out 1: dst has data worth draining.
- dst_end out 1: dst head is valid and tagged last.
- src_level out AW+1: src occupancy.
- dst_level out AW+1: dst occupancy.
- ocnt out 16: count of non-last dst pushes.
- icnt out 16: count of accepted src writes.
- err out 2: sticky flags; [0] overflow, [1] underflow.

Behaviour:
- Reset: on wb_rst_n low, both FIFOs are empty and the pointers, levels, ocnt, icnt and err are 0. Output values while in reset:
  - empty = 1, almost_empty = 1;
  - full = 0, almost_full = 0, stop = 0, dst_end = 0;
  - src_start = 1, dst_start = 0;
  - data outputs are don't-care.
- m_reset: same effect as reset, taken on the clock edge. It has priority over all pushes and pops in that cycle. src_start = 0 while m_reset is high.
- FIFO write/read:
  - A write is accepted when wr & !full, or when wr & rd & full.
  - A read is accepted when rd & !empty.
  - level updates by +1 (write only), -1 (read only) or 0 (both) on the clock edge.
  - All flags are decoded combinationally from the registered level.
  - A written word appears at the head one cycle after the write (the empty→non-empty transition takes one cycle).
- Rejected operations:
  - A write to a full FIFO is dropped and sets err[0].
  - A read from an empty FIFO is ignored and sets err[1].
  - A simultaneous read and write on an empty FIFO accepts the write and sets err[1].
- Pointers wrap modulo 2**AW. Full is level == 2**AW.
- src path:
  - write = src_xfer, data = swap(src_dat_o), tag = src_last.
  - read = !m_src_getn.
  - src_start = !m_reset & (2**AW - src_level > AFULL_MARGIN).
- dst path:
  - write = !m_dst_putn, data = swap(m_dst), tag = m_dst_last.
  - read = (dst_xfer & !dst_end) | (dst_last_pop & dst_end).
  - While dst_end is high, dst_xfer does not pop and does not set err[1].
  - dst_start = m_dst_almost_full | (!m_endn & !dst_empty).
- swap(x): byte k maps to byte DW/8-1-k when SWAP_EN = 1; identity otherwise.
- ocnt increments on a dst push with m_dst_last = 0 and counts regardless of whether the FIFO is full. icnt increments on each accepted src write. Both counters wrap at 16 bits.
- err bits clear only on reset or m_reset.

Decomposition:
- Package ch_pkg holds:
  - the tagged-word typedef {last, data[DW-1:0]};
  - the swap function;
  - the err bit index constants.
- Sub-module ch_sfifo: a synchronous FIFO with these interfaces:
  - parameters W and AW;
  - ports wr, rd, din, dout, level, full, empty and ovf/udf pulses.
- ch_sfifo is instantiated twice. Threshold decode and the counters live at the top level.

Test Plan:
- Reset: hold wb_rst_n = 0 → m_src_empty = 1, src_start = 1, dst_start = 0, ocnt = 0, err = 0.
- src path: write 0x0102030405060708 with SWAP_EN = 1 → m_src = 0x0807060504030201 one cycle later; pop → m_src_empty = 1; icnt = 1.
- dst threshold: push 256 words → m_dst_almost_full = dst_stop = dst_start = 1. Push to 512 → m_dst_full = 1. Push once more → word dropped, err = 2'b01, level stays 512.
- dst end: push 3 words, the last tagged last; assert dst_xfer continuously → exactly 2 pops, then dst_end = 1 and level stays 1. Pulse dst_last_pop → level = 0. ocnt = 2.
- Simultaneous and empty cases: read and write together on a full src FIFO → level stays 512, no error. Read and write together on an empty FIFO → level = 1, err[1] = 1.
- Clear mid-burst: assert m_reset during a burst → both levels, counters and err = 0 next cycle; src_start = 0 during m_reset.
